apb_uart_req_arbiter: RTL



---
 rtl/apb_uart_req_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/apb_uart_req_arbiter.sv
// Two-requester round-robin APB master sharing the UART register port.
// Define APB_ARB_TIMEOUT_EN to abort stalled ACCESS phases with err = 1.
module apb_uart_req_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req0,
    input  logic        wr0,
    input  logic [7:0]  addr0,
    input  logic [7:0]  wdata0,
    output logic        ack0,
    input  logic        req1,
    input  logic        wr1,
    input  logic [7:0]  addr1,
    input  logic [7:0]  wdata1,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        owner,
    output logic        busy,
    output logic        transfer,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [7:0]  PADDR,
    output logic [7:0]  PWDATA,
    input  logic        PREADY,
    input  logic [31:0] PRDATA
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t     state;
    logic       last_grant;
    logic       gnt_sel;
    logic       gnt_wr;
    logic [7:0] gnt_addr;
    logic [7:0] gnt_wdata;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt;
`endif

    // A tie goes to whoever did not win last time.
    always_comb begin
        gnt_sel   = req1 & (~req0 | ~last_grant);
        gnt_wr    = gnt_sel ? wr1 : wr0;
        gnt_addr  = gnt_sel ? addr1 : addr0;
        gnt_wdata = gnt_sel ? wdata1 : wdata0;
    end

    assign busy = transfer;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            transfer   <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= 8'h00;
            PWDATA     <= 8'h00;
            rdata      <= 32'h0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err        <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt        <= 16'h0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner      <= gnt_sel;
                        last_grant <= gnt_sel;
                        PWRITE     <= gnt_wr;
                        PADDR      <= gnt_addr;
                        PWDATA     <= gnt_wdata;
                        transfer   <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    cnt     <= 16'h0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        state    <= IDLE;
                        transfer <= 1'b0;
                        PENABLE  <= 1'b0;
                        ack0     <= ~owner;
                        ack1     <= owner;
                        if (!PWRITE) begin
                            rdata <= PRDATA;
                        end
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (cnt == TMO_LAST) begin
                        state    <= IDLE;
                        transfer <= 1'b0;
                        PENABLE  <= 1'b0;
                        ack0     <= ~owner;
                        ack1     <= owner;
                        err      <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
